// File: rtl/cl_fcs_pkg.sv
// cl_fcs_pkg: shared state encoding, CRC-32 constants and the byte-wide reflected CRC step.
package cl_fcs_pkg;
  typedef enum logic [1:0] {S_PAYLOAD, S_PAD, S_FCS} state_t;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_XOROUT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc, input logic [7:0] data,
                                                    input logic [31:0] poly);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = (c >> 1) ^ (c[0] ? poly : 32'h0);
    return c;
  endfunction
endpackage

// File: rtl/cl_fcs_inserter_crc.sv
// cl_crc32_byte: combinational one-byte reflected CRC-32 update.
module cl_crc32_byte import cl_fcs_pkg::*; #(
  parameter logic [31:0] POLY = CRC32_POLY
) (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  assign crc_out = crc32_byte_update(crc_in, data, POLY);
endmodule

// File: rtl/cl_fcs_inserter.sv
// cl_fcs_inserter: byte-stream FCS inserter with optional zero padding to a minimum frame length.
module cl_fcs_inserter import cl_fcs_pkg::*; #(
  parameter int unsigned PAD_MIN    = 60,
  parameter logic [31:0] CRC_INIT   = CRC32_INIT,
  parameter logic [31:0] CRC_POLY   = CRC32_POLY,
  parameter logic [31:0] CRC_XOROUT = CRC32_XOROUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);
  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_nx, fcs;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [7:0]  out_data_q, out_data_d, crc_byte;
  logic        free, accept, cnt_lt;
  assign free      = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_PAYLOAD) && free;
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = &cnt_q ? cnt_q : cnt_q + 16'd1;
  assign cnt_lt    = {16'd0, cnt_inc} < PAD_MIN;
  assign fcs       = crc_q ^ CRC_XOROUT;
  assign crc_byte  = (state_q == S_PAD) ? 8'h00 : in_data;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  // One CRC engine serves both payload and pad bytes.
  cl_crc32_byte #(.POLY(CRC_POLY)) u_crc (
    .crc_in (crc_q),
    .data   (crc_byte),
    .crc_out(crc_nx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_PAYLOAD;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PAYLOAD: if (accept && in_last) state_d = cnt_lt ? S_PAD : S_FCS;
      S_PAD:     if (free && !cnt_lt) state_d = S_FCS;
      S_FCS:     if (free && &idx_q) state_d = S_PAYLOAD;
      default:   state_d = S_PAYLOAD;
    endcase
  end
  // Output registers only move when free, so a stalled byte is never changed.
  always_comb begin
    out_valid_d = free ? 1'b0 : out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    if (free) begin
      case (state_q)
        S_PAYLOAD: if (in_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_last_d  = 1'b0;
          crc_d       = crc_nx;
          cnt_d       = cnt_inc;
        end
        S_PAD: begin
          out_valid_d = 1'b1;
          out_data_d  = 8'h00;
          out_last_d  = 1'b0;
          crc_d       = crc_nx;
          cnt_d       = cnt_inc;
        end
        S_FCS: begin
          out_valid_d = 1'b1;
          out_data_d  = fcs[{idx_q, 3'b000} +: 8];
          out_last_d  = &idx_q;
          idx_d       = idx_q + 2'd1;
          crc_d       = &idx_q ? CRC_INIT : crc_q;
          cnt_d       = &idx_q ? 16'd0 : cnt_q;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      crc_q       <= CRC_INIT;
      cnt_q       <= 16'd0;
      idx_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
    end
  end
endmodule

// File: tb/tb_cl_fcs_inserter.sv
// tb_cl_fcs_inserter: randomized frame traffic against a queue-based model of pad + CRC-32 framing.
module tb_cl_fcs_inserter;
  localparam logic [31:0] POLY    = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
  logic clk = 0, rst_n = 1;
  logic in_valid = 0, in_last = 0, out_ready = 1, sel = 0, rand_rdy = 0;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, out_last;
  logic [7:0] out_data;
  logic ir0, ov0, ol0, ir1, ov1, ol1;
  logic [7:0] od0, od1;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [7:0] tx[$], ref_pay[$], ob_d[$];
  bit tx_last[$], ob_l[$];
  int ref_len[$], ob_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cl_fcs_inserter #(.PAD_MIN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(ir0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0));
  cl_fcs_inserter #(.PAD_MIN(60)) u60 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(ir1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1));

  assign in_ready  = sel ? ir1 : ir0;
  assign out_valid = sel ? ov1 : ov0;
  assign out_data  = sel ? od1 : od0;
  assign out_last  = sel ? ol1 : ol0;

  always @(negedge clk) out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  always @(negedge clk) begin
    #3;
    if (out_valid && out_ready) begin
      ob_d.push_back(out_data);
      ob_l.push_back(out_last);
      ob_c.push_back(cyc);
    end
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = ((b[i] ^ c[0]) != 0) ? ((c >> 1) ^ POLY) : (c >> 1);
    return c;
  endfunction

  task automatic clear();
    tx.delete(); tx_last.delete(); ref_pay.delete(); ref_len.delete();
    ob_d.delete(); ob_l.delete(); ob_c.delete();
  endtask

  // mode 0: random bytes, 1: ASCII "123...", 2: all zero
  task automatic add_frame(input int len, input int mode);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = (mode == 1) ? 8'(8'h31 + k) : (mode == 2) ? 8'h00 : 8'($urandom_range(0, 255));
      tx.push_back(b); ref_pay.push_back(b); tx_last.push_back(k == len - 1);
    end
    ref_len.push_back(len);
  endtask

  task automatic drive(input int gap_pct);
    int i = 0, guard = 0;
    while (i < tx.size() && guard < 40000) begin
      @(negedge clk);
      guard++;
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = tx[i];
      in_last  = tx_last[i];
      #2;
      if (in_valid && in_ready) i++;
    end
    @(negedge clk);
    in_valid = 0;
    if (i < tx.size()) begin
      miscompares++;
      $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i, tx.size());
    end
  endtask

  task automatic wait_beats(input string name, input int pad_min);
    int need = 0, t = 0;
    foreach (ref_len[f]) need += ((ref_len[f] > pad_min) ? ref_len[f] : pad_min) + 4;
    while (ob_d.size() < need && t < 40000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    vectors++;
    if (ob_d.size() != need) begin
      miscompares++;
      $display("FAIL %s beat_count: got %0d, expected %0d", name, ob_d.size(), need);
    end
  endtask

  task automatic check_all(input string name, input int pad_min);
    int p = 0, off = 0;
    for (int f = 0; f < ref_len.size(); f++) begin
      logic [7:0] e[$];
      logic [31:0] c;
      int bad, n;
      e = {};
      bad = -1;
      for (int k = 0; k < ref_len[f]; k++) e.push_back(ref_pay[off + k]);
      off += ref_len[f];
      while (e.size() < pad_min) e.push_back(8'h00);
      c = 32'hFFFF_FFFF;
      foreach (e[k]) c = crc_step(c, e[k]);
      c = ~c;
      for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
      n = e.size();
      vectors++;
      if (p + n > ob_d.size()) begin
        miscompares++;
        $display("FAIL %s frame%0d short: got %0d beats, expected %0d", name, f, ob_d.size() - p, n);
        return;
      end
      for (int k = n - 1; k >= 0; k--)
        if (ob_d[p+k] !== e[k] || ob_l[p+k] !== (k == n - 1)) bad = k;
      if (bad >= 0) begin
        miscompares++;
        $display("FAIL %s frame%0d beat%0d: got data %h last %0d, expected data %h last %0d",
                 name, f, bad, ob_d[p+bad], ob_l[p+bad], e[bad], (bad == n - 1));
      end
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < n; k++) c = crc_step(c, ob_d[p+k]);
      vectors++;
      if (c !== RESIDUE) begin
        miscompares++;
        $display("FAIL %s frame%0d residue: got %h, expected %h", name, f, c, RESIDUE);
      end
      p += n;
    end
  endtask

  task automatic check_fcs_const(input string name, input int p);
    vectors++;
    if (ob_d.size() < p + 4) begin
      miscompares++;
      $display("FAIL %s fcs: got %0d beats, expected at least %0d", name, ob_d.size(), p + 4);
    end else if ({ob_d[p], ob_d[p+1], ob_d[p+2], ob_d[p+3]} !== 32'h2639_F4CB) begin
      miscompares++;
      $display("FAIL %s fcs: got %h %h %h %h, expected 26 39 f4 cb", name,
               ob_d[p], ob_d[p+1], ob_d[p+2], ob_d[p+3]);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    vectors++;
    if ({out_valid, out_data, out_last} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v%0b d%h l%0b, expected v0 d00 l0", out_valid, out_data, out_last);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    #2;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_check_vector();
    clear(); sel = 0; rand_rdy = 0;
    add_frame(9, 1);
    drive(0);
    wait_beats("check_vector", 0);
    check_all("check_vector", 0);
    check_fcs_const("check_vector", 9);
  endtask

  task automatic test_pad();
    int lows = 0;
    clear(); sel = 1; rand_rdy = 0;
    add_frame(1, 2);
    drive(0);
    for (int k = 0; k < 63; k++) begin
      #2;
      if (!in_ready) lows++;
      @(negedge clk);
    end
    #2;
    vectors++;
    if (lows != 63 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pad_in_ready: got %0d low cycles then %b, expected 63 then 1", lows, in_ready);
    end
    wait_beats("pad", 60);
    check_all("pad", 60);
  endtask

  task automatic test_no_pad();
    clear(); sel = 1; rand_rdy = 0;
    add_frame(100, 0);
    drive(0);
    wait_beats("no_pad", 60);
    check_all("no_pad", 60);
  endtask

  task automatic test_random();
    clear(); sel = 1; rand_rdy = 1;
    for (int f = 0; f < 20; f++) add_frame($urandom_range(1, 200), 0);
    drive(30);
    wait_beats("random", 60);
    rand_rdy = 0;
    check_all("random", 60);
  endtask

  task automatic test_back_to_back();
    int n1;
    clear(); sel = 0; rand_rdy = 0;
    add_frame($urandom_range(5, 20), 0);
    add_frame($urandom_range(5, 20), 0);
    n1 = ref_len[0] + 4;
    drive(0);
    wait_beats("back_to_back", 0);
    vectors++;
    if (ob_c.size() <= n1 || ob_c[n1] != ob_c[n1-1] + 1) begin
      miscompares++;
      $display("FAIL back_to_back gap: got frame2 start cycle %0d, expected %0d",
               (ob_c.size() > n1) ? ob_c[n1] : -1, (ob_c.size() >= n1) ? ob_c[n1-1] + 1 : -1);
    end
    check_all("back_to_back", 0);
  endtask

  task automatic test_reset_mid_fcs();
    int t = 0;
    clear(); sel = 0; rand_rdy = 0;
    add_frame(9, 1);
    drive(0);
    while (ob_d.size() < 10 && t < 100) begin @(negedge clk); #4; t++; end
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    vectors++;
    if (ob_d.size() != 10 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_fcs: got beats %0d valid %b last %b, expected 10 0 0", ob_d.size(), out_valid, out_last);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    clear();
    add_frame(9, 1);
    drive(0);
    wait_beats("after_reset", 0);
    check_all("after_reset", 0);
    check_fcs_const("after_reset", 9);
  endtask

  initial begin
    test_reset();
    test_check_vector();
    test_pad();
    test_no_pad();
    test_random();
    test_back_to_back();
    test_reset_mid_fcs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
